// File: rtl/baccarat_round_ctrl_if.sv
// Handshake and datapath-feedback bundle between the baccarat round controller and its
// card source / hand datapath.
interface baccarat_round_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             card_valid;
    logic [3:0]       pscore;
    logic [3:0]       dscore;
    logic [3:0]       pcard3;
    logic             card_req;
    logic             clear_hand;
    logic             load_pcard1;
    logic             load_pcard2;
    logic             load_pcard3;
    logic             load_dcard1;
    logic             load_dcard2;
    logic             load_dcard3;
    logic             busy;
    logic             player_win_light;
    logic             dealer_win_light;
    logic             error;
    logic [CNT_W-1:0] player_wins;
    logic [CNT_W-1:0] dealer_wins;
    logic [CNT_W-1:0] ties;

    modport master (
        input  start, card_valid, pscore, dscore, pcard3,
        output card_req, clear_hand,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output busy, player_win_light, dealer_win_light, error,
        output player_wins, dealer_wins, ties
    );

    modport slave (
        output start, card_valid, pscore, dscore, pcard3,
        input  card_req, clear_hand,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  busy, player_win_light, dealer_win_light, error,
        input  player_wins, dealer_wins, ties
    );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat sequencer: deals cards over a req/valid handshake, applies the
// third-card rules, scores the hand and keeps saturating win/tie tallies.
module baccarat_round_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                   slow_clock,
    input logic                   resetb,
    baccarat_round_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StReqP1,
        StReqD1,
        StReqP2,
        StReqD2,
        StEval2,
        StReqP3,
        StEval3,
        StReqD3,
        StResult,
        StDone,
        StError
    } state_t;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_t           r_state;
    logic [15:0]      r_timer;
    logic             r_player_light;
    logic             r_dealer_light;
    logic             r_error;
    logic [CNT_W-1:0] r_player_wins;
    logic [CNT_W-1:0] r_dealer_wins;
    logic [CNT_W-1:0] r_ties;

    logic   w_is_req;
    logic   w_idle_like;
    logic   w_natural;
    logic   w_banker_draw;
    state_t w_req_next;

    always_comb begin
        w_is_req = 1'b0;
        unique case (r_state)
            StReqP1, StReqD1, StReqP2, StReqD2, StReqP3, StReqD3: w_is_req = 1'b1;
            default: w_is_req = 1'b0;
        endcase
    end

    assign w_idle_like = (r_state == StIdle) || (r_state == StDone) || (r_state == StError);
    assign w_natural   = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);

    always_comb begin
        w_req_next = StResult;
        case (r_state)
            StReqP1: w_req_next = StReqD1;
            StReqD1: w_req_next = StReqP2;
            StReqP2: w_req_next = StReqD2;
            StReqD2: w_req_next = StEval2;
            StReqP3: w_req_next = StEval3;
            default: w_req_next = StResult;
        endcase
    end

    // Banker tableau once the player has drawn: two-card banker total vs player third card.
    always_comb begin
        w_banker_draw = 1'b0;
        case (bus.dscore)
            4'd0, 4'd1, 4'd2: w_banker_draw = 1'b1;
            4'd3: w_banker_draw = (bus.pcard3 != 4'd8);
            4'd4: w_banker_draw = (bus.pcard3 >= 4'd2) && (bus.pcard3 <= 4'd7);
            4'd5: w_banker_draw = (bus.pcard3 >= 4'd4) && (bus.pcard3 <= 4'd7);
            4'd6: w_banker_draw = (bus.pcard3 >= 4'd6) && (bus.pcard3 <= 4'd7);
            default: w_banker_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_state        <= StIdle;
            r_timer        <= 16'd0;
            r_player_light <= 1'b0;
            r_dealer_light <= 1'b0;
            r_error        <= 1'b0;
            r_player_wins  <= '0;
            r_dealer_wins  <= '0;
            r_ties         <= '0;
        end else begin
            case (r_state)
                StIdle, StDone, StError: begin
                    if (bus.start) r_state <= StClear;
                end
                StClear: begin
                    r_player_light <= 1'b0;
                    r_dealer_light <= 1'b0;
                    r_error        <= 1'b0;
                    r_timer        <= 16'd0;
                    r_state        <= StReqP1;
                end
                StReqP1, StReqD1, StReqP2, StReqD2, StReqP3, StReqD3: begin
                    // A card in the expiry cycle still wins over the timeout.
                    if (bus.card_valid) begin
                        r_timer <= 16'd0;
                        r_state <= w_req_next;
                    end else if (r_timer == TmoLast) begin
                        r_timer <= 16'd0;
                        r_error <= 1'b1;
                        r_state <= StError;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                StEval2: begin
                    if (w_natural) begin
                        r_state <= StResult;
                    end else if (bus.pscore <= 4'd5) begin
                        r_state <= StReqP3;
                    end else if (bus.dscore <= 4'd5) begin
                        r_state <= StReqD3;
                    end else begin
                        r_state <= StResult;
                    end
                end
                StEval3: begin
                    r_state <= w_banker_draw ? StReqD3 : StResult;
                end
                StResult: begin
                    if (bus.pscore > bus.dscore) begin
                        r_player_light <= 1'b1;
                        r_dealer_light <= 1'b0;
                        if (r_player_wins != CntMax) r_player_wins <= r_player_wins + 1'b1;
                    end else if (bus.dscore > bus.pscore) begin
                        r_player_light <= 1'b0;
                        r_dealer_light <= 1'b1;
                        if (r_dealer_wins != CntMax) r_dealer_wins <= r_dealer_wins + 1'b1;
                    end else begin
                        r_player_light <= 1'b1;
                        r_dealer_light <= 1'b1;
                        if (r_ties != CntMax) r_ties <= r_ties + 1'b1;
                    end
                    r_state <= StDone;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Load strobes are Mealy so the datapath captures the card on the accepting edge.
    assign bus.load_pcard1 = (r_state == StReqP1) && bus.card_valid;
    assign bus.load_dcard1 = (r_state == StReqD1) && bus.card_valid;
    assign bus.load_pcard2 = (r_state == StReqP2) && bus.card_valid;
    assign bus.load_dcard2 = (r_state == StReqD2) && bus.card_valid;
    assign bus.load_pcard3 = (r_state == StReqP3) && bus.card_valid;
    assign bus.load_dcard3 = (r_state == StReqD3) && bus.card_valid;

    assign bus.card_req         = w_is_req;
    assign bus.clear_hand       = (r_state == StClear);
    assign bus.busy             = !w_idle_like;
    assign bus.player_win_light = r_player_light;
    assign bus.dealer_win_light = r_dealer_light;
    assign bus.error            = r_error;
    assign bus.player_wins      = r_player_wins;
    assign bus.dealer_wins      = r_dealer_wins;
    assign bus.ties             = r_ties;

endmodule
